multi_prescaler: RTL
====================

Name: multi_prescaler

Overview:
Multi-channel programmable clock divider. It is the parametrised successor of the single fixed-ratio prescaler.
- Each channel toggles its own divided clock every N input cycles, where N is a per-channel divisor.
- Divisors can be changed at runtime through a valid/ready config port. A new divisor takes effect only at a half-period boundary, so the output never has a short half-period.
- Per-channel enable and one-cycle tick strobes feed the dice display and scan logic.

Parameters:
NUM_CH, 4, number of independent divider channels (>=1)
CNT_W, 16, width of divisor and counters
DEFAULT_DIV, 1000, divisor loaded into every channel at reset (1 <= DEFAULT_DIV < 2^CNT_W)
CH_W, $clog2(NUM_CH) (min 1), width of channel select

Ports:
clk_in  input  1  system clock
rst  input  1  reset, asynchronous, active-low
en  input  NUM_CH  per-channel run enable
cfg_valid  input  1  divisor write request
cfg_ch  input  CH_W  target channel of write
cfg_div  input  CNT_W  new half-period divisor N
cfg_ready  output  1  write slot free; write accepted when cfg_valid && cfg_ready at a clk_in rising edge
clk_out  output  NUM_CH  divided clocks, period 2N, 50% duty
tick  output  NUM_CH  one-cycle strobe coincident with each clk_out toggle

Behaviour:
- Reset (rst=0, async, no clock needed):
  - all counters = 0, clk_out = 0, tick = 0, cfg_ready = 1.
  - active divisor of every channel = DEFAULT_DIV.
  - pending write discarded.
- Per channel c, with en[c]=1 and active divisor N:
  - each edge: if counter == N-1, then counter <= 0, clk_out[c] <= ~clk_out[c], tick[c] <= 1.
  - otherwise counter <= counter+1, tick[c] <= 0.
  - first toggle occurs on the N-th rising edge after the counter leaves 0.
- Divisor 0 is treated as 1: toggle every cycle, tick[c] held high.
- en[c]=0 at an edge: counter <= 0, clk_out[c] <= 0, tick[c] <= 0.
  - Re-enable starts a full N-cycle half-period from counter 0.
- Config path:
  - One global pending slot (pend_valid, pend_ch, pend_div). cfg_ready = ~pend_valid, driven from a register or directly from flops.
  - On accept: pend_valid <= 1 and pending fields are captured. cfg_ready goes low from the next cycle.
  - If pend_ch >= NUM_CH, the write is dropped on the cycle after accept: pend_valid <= 0, and no channel changes.
- Apply rule:
  - Pending is applied to channel pend_ch at the first edge where that channel is at a boundary (en=1 and counter == N-1), or at any edge where en[pend_ch]=0.
  - At that edge the active divisor <= pend_div and pend_valid <= 0. The toggle and counter reset that happen at the same edge use the old N; the next half-period uses the new N.
  - A write accepted on the same edge a channel is at a boundary is not applied there; it waits for the next boundary.
- Widths:
  - counter is CNT_W bits and compares against N-1 computed in CNT_W bits, with 0 mapped to 1 first.
  - No overflow is possible, since counter never exceeds N-1.
- Independence: channels never interact except through the shared pending slot. Only one divisor change can be in flight at a time.
- Reset mid-operation: same as the reset values above, on every output.

Test Plan:
1. Release reset, en=4'b1111, defaults → clk_out[0] rises at the 1000th edge and falls at the 2000th; tick[0] is high exactly on edges 1000, 2000, …; all four channels are identical.
2. Channel 1 running N=1000, at counter=500 write ch=1, div=3 → cfg_ready low for about 500 cycles; the current half-period stays 1000 cycles; half-periods are 3 cycles afterwards; cfg_ready returns to 1 the cycle after apply.
3. en[2]=0, write ch=2, div=0 → applied on the next edge, cfg_ready back to 1 after one cycle; then set en[2]=1 → clk_out[2] toggles every cycle and tick[2] stays high.
4. Channel 3 at counter=400, N=1000, drop en[3] for 5 cycles and then raise it → clk_out[3]=0 the cycle after the drop; the next rise occurs 1000 edges after re-enable.
5. Assert rst low mid-period between clock edges → clk_out=0, tick=0 and cfg_ready=1 immediately; after release, divisors are back to 1000.
6. NUM_CH=4, write cfg_ch=5 (CH_W=2 builds cannot express this, so run with NUM_CH=3 and cfg_ch=3) → handshake completes, cfg_ready low for one cycle, and no channel period changes.

Source files
------------

// File: rtl/multi_prescaler.sv
// multi_prescaler: multi-channel programmable clock divider with a valid/ready divisor update port
//   clk_in    system clock
//   rst       asynchronous active-low reset
//   en        per-channel run enable
//   cfg_valid divisor write request; cfg_ch target channel, cfg_div new half-period divisor
//   cfg_ready single pending slot free
//   clk_out   divided clocks, period 2N, 50% duty
//   tick      one-cycle strobe on every clk_out toggle
module multi_prescaler #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 1000,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);
  localparam logic [CH_W:0]    LP_NCH = (CH_W + 1)'(NUM_CH);
  localparam logic [CNT_W-1:0] LP_DEF = CNT_W'(DEFAULT_DIV);
  logic [CNT_W-1:0]  r_cnt [NUM_CH];
  logic [CNT_W-1:0]  r_div [NUM_CH];
  logic [CNT_W-1:0]  w_lim [NUM_CH];
  logic [NUM_CH-1:0] r_clk, r_tick, w_bnd, w_apply;
  logic              r_pend_valid;
  logic [CH_W-1:0]   r_pend_ch;
  logic [CNT_W-1:0]  r_pend_div;
  logic              w_pend_bad, w_accept;
  assign cfg_ready = ~r_pend_valid;
  assign clk_out   = r_clk;
  assign tick      = r_tick;
  // Divisor 0 behaves as 1, so its terminal count is 0 as well.
  // A pending write lands on its channel at a half-period boundary or while the channel is idle.
  always_comb begin
    w_pend_bad = r_pend_valid && ({1'b0, r_pend_ch} >= LP_NCH);
    w_accept   = cfg_valid && !r_pend_valid;
    for (int c = 0; c < NUM_CH; c++) begin
      w_lim[c]   = (r_div[c] == '0) ? '0 : r_div[c] - 1'b1;
      w_bnd[c]   = en[c] && (r_cnt[c] == w_lim[c]);
      w_apply[c] = r_pend_valid && (r_pend_ch == CH_W'(c)) && (w_bnd[c] || !en[c]);
    end
  end
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c] <= '0;
        r_div[c] <= LP_DEF;
      end
      r_clk        <= '0;
      r_tick       <= '0;
      r_pend_valid <= 1'b0;
      r_pend_ch    <= '0;
      r_pend_div   <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c]  <= (!en[c] || w_bnd[c]) ? '0 : r_cnt[c] + 1'b1;
        r_clk[c]  <= en[c] && (r_clk[c] ^ w_bnd[c]);
        r_tick[c] <= w_bnd[c];
        if (w_apply[c]) r_div[c] <= r_pend_div;
      end
      if (w_accept) begin
        r_pend_valid <= 1'b1;
        r_pend_ch    <= cfg_ch;
        r_pend_div   <= cfg_div;
      end else if (w_pend_bad || |w_apply) begin
        r_pend_valid <= 1'b0;
      end
    end
  end
endmodule
